// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and helpers for the IF stage (fetch_unit).
// Optional feature macro used by the fetch files: FETCH_BPRED_EN (2-bit BHT).
package fetch_unit_pkg;

    // PC value the fetch stage starts from after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        CANCEL = 3'd4
    } fetch_state_t;

    // Registered bundle handed from IF to ID.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        addr_err_if;
        logic        in_delay_slot;
        logic        is_instr;
    } dp_ftod;

    localparam dp_ftod FTOD_RESET = '{
        instr:         32'h0000_0000,
        pc:            32'h0000_0000,
        pcplus4:       32'h0000_0000,
        addr_err_if:   1'b0,
        in_delay_slot: 1'b0,
        is_instr:      1'b0
    };

    // Instruction fetches must be word aligned; only the two low PC bits matter.
    function automatic logic pc_misaligned(input logic [1:0] pc_low);
        return (pc_low != 2'b00);
    endfunction

    // Saturating 2-bit branch counter step.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (ctr == 2'b11) begin
                res = 2'b11;
            end else begin
                res = ctr + 2'b01;
            end
        end else begin
            if (ctr == 2'b00) begin
                res = 2'b00;
            end else begin
                res = ctr - 2'b01;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// fetch_bht: table of 2-bit saturating branch counters used by fetch_unit.
// Only compiled in when FETCH_BPRED_EN is defined.
// Reads are combinational; a same-cycle update to the read index is seen
// on the following cycle, so a simultaneous read returns the old value.
`ifdef FETCH_BPRED_EN
module fetch_bht
    import fetch_unit_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr_r [ENTRIES];

    // Counter table: weakly not-taken at reset, saturating step on each resolved branch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= 2'b01;
            end
        end else if (upd_en) begin
            ctr_r[upd_idx] <= sat_update(ctr_r[upd_idx], upd_taken);
        end
    end

    assign rd_taken = ctr_r[rd_idx][1];

endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Holds the PC, issues single outstanding reads on the
// SRAM-like instruction bus and registers the ftod bundle for ID.
// Optional feature macro: FETCH_BPRED_EN adds a 2-bit BHT (fetch_bht) whose
// prediction for the fetched PC is registered alongside ftod as d_guess_taken.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] f_nextpc,
    input  logic        f_indelayslot,
    input  logic        stall_d,
    input  logic        flush_f,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] f_nowpc,
    output logic [31:0] f_pcplus4,
    output logic        f_busy,
    output logic [31:0] ftod_instr,
    output logic [31:0] ftod_pc,
    output logic [31:0] ftod_pcplus4,
    output logic        ftod_addr_err_if,
    output logic        ftod_in_delay_slot,
    output logic        ftod_is_instr,
    output logic        d_guess_taken,
    input  logic        bht_upd_en,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken
);

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;

    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] buf_instr_r;
    logic        buf_err_r;
    dp_ftod      ftod_r;
    logic        guess_r;

    logic        advance_s;
    logic        take_data_s;
    logic        load_idle_s;
    logic        pred_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // ------------------------------------------------------------------
    // Branch history table (optional)
    // ------------------------------------------------------------------
`ifdef FETCH_BPRED_EN
    logic unused_upd_s;

    fetch_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk       (clk),
        .resetn    (resetn),
        .rd_idx    (pc_r[BHT_IDX_W+1:2]),
        .rd_taken  (pred_s),
        .upd_en    (bht_upd_en),
        .upd_idx   (bht_upd_pc[BHT_IDX_W+1:2]),
        .upd_taken (bht_upd_taken)
    );

    // PC bits outside the table index do not take part in prediction.
    assign unused_upd_s = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};
`else
    logic unused_upd_s;

    assign pred_s       = 1'b0;
    // Without the predictor the update port is accepted and ignored.
    assign unused_upd_s = ^{bht_upd_en, bht_upd_pc, bht_upd_taken, 32'(BHT_IDX_W)};
`endif

    // ------------------------------------------------------------------
    // Fetch sequencer
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and per-cycle strobes; flush wins over stall and advance,
    // and an accepted request under flush must still drain its data beat.
    always_comb begin
        state_nxt_s = state_r;
        advance_s   = 1'b0;
        take_data_s = 1'b0;
        load_idle_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush_f) begin
                    state_nxt_s = IDLE;
                end else begin
                    load_idle_s = 1'b1;
                    if (pc_misaligned(pc_r[1:0])) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
            end
            REQ: begin
                if (inst_addr_ok && inst_data_ok) begin
                    if (flush_f) begin
                        state_nxt_s = IDLE;
                    end else begin
                        take_data_s = 1'b1;
                        state_nxt_s = DONE;
                    end
                end else if (inst_addr_ok) begin
                    if (flush_f) begin
                        state_nxt_s = CANCEL;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    if (flush_f) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (flush_f) begin
                        state_nxt_s = IDLE;
                    end else begin
                        take_data_s = 1'b1;
                        state_nxt_s = DONE;
                    end
                end else begin
                    if (flush_f) begin
                        state_nxt_s = CANCEL;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
            end
            DONE: begin
                if (flush_f) begin
                    state_nxt_s = IDLE;
                end else if (!stall_d) begin
                    advance_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            CANCEL: begin
                if (inst_data_ok) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CANCEL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // PC: redirected on flush, otherwise reloaded from ID on each advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r <= RESET_PC;
        end else if (flush_f || advance_s) begin
            pc_r <= f_nextpc;
        end
    end

    // Fetch buffer: cleared with the alignment verdict when a fetch starts,
    // then filled by the accepted data beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_instr_r <= 32'h0000_0000;
            buf_err_r   <= 1'b0;
        end else if (load_idle_s) begin
            buf_instr_r <= 32'h0000_0000;
            buf_err_r   <= pc_misaligned(pc_r[1:0]);
        end else if (take_data_s) begin
            buf_instr_r <= inst_rdata;
        end
    end

    // ftod register: flush inserts a bubble, advance loads the completed fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ftod_r  <= FTOD_RESET;
            guess_r <= 1'b0;
        end else if (flush_f) begin
            ftod_r.is_instr <= 1'b0;
        end else if (advance_s) begin
            ftod_r.instr         <= buf_instr_r;
            ftod_r.pc            <= pc_r;
            ftod_r.pcplus4       <= pc_plus4_s;
            ftod_r.addr_err_if   <= buf_err_r;
            ftod_r.in_delay_slot <= f_indelayslot;
            ftod_r.is_instr      <= 1'b1;
            guess_r              <= pred_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    assign inst_req           = (state_r == REQ);
    assign inst_addr          = pc_r;
    assign f_nowpc            = pc_r;
    assign f_pcplus4          = pc_plus4_s;
    assign f_busy             = (state_r != DONE);

    assign ftod_instr         = ftod_r.instr;
    assign ftod_pc            = ftod_r.pc;
    assign ftod_pcplus4       = ftod_r.pcplus4;
    assign ftod_addr_err_if   = ftod_r.addr_err_if;
    assign ftod_in_delay_slot = ftod_r.in_delay_slot;
    assign ftod_is_instr      = ftod_r.is_instr;
    assign d_guess_taken      = guess_r;

endmodule
